// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit driving a valid/ready bus and formatting load/store data
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  load_valid,
  output logic                  fault,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0] off_q, off_d;
  logic [2:0] f3_q, f3_d;
  logic we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, mem_data_q, mem_data_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic start, bad;
  logic [DATA_WIDTH-1:0] wdata_fmt, shifted, ld_fmt;
  logic [3:0] wstrb_fmt;
  assign start = req_valid & (mem_read | mem_write);
  assign bad = (mem_read & mem_write) | (funct3[1:0] == 2'b11) | (funct3 == 3'b110) |
               (mem_write & funct3[2]) | ((funct3[1:0] == 2'b01) & addr[0]) |
               ((funct3[1:0] == 2'b10) & (|addr[1:0]));
  assign wdata_fmt = (funct3[1:0] == 2'b00) ? {4{store_data[7:0]}} :
                     (funct3[1:0] == 2'b01) ? {2{store_data[15:0]}} : store_data;
  assign wstrb_fmt = !mem_write ? 4'b0000 :
                     (funct3[1:0] == 2'b00) ? (4'b0001 << addr[1:0]) :
                     (funct3[1:0] == 2'b01) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign shifted = bus_rdata >> {off_q, 3'b000};
  assign ld_fmt = (f3_q[1:0] == 2'b00) ? {{(DATA_WIDTH-8){~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                  (f3_q[1:0] == 2'b01) ? {{(DATA_WIDTH-16){~f3_q[2] & shifted[15]}}, shifted[15:0]} :
                  bus_rdata;
  assign bus_req_valid = (state_q == REQ);
  assign bus_we = we_q;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign mem_data = mem_data_q;
  // next-state, request capture and handshake outputs
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    off_d = off_q;
    f3_d = f3_q;
    we_d = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    mem_data_d = mem_data_q;
    stall = 1'b0;
    fault = 1'b0;
    load_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && bad) fault = 1'b1;
        else if (start) begin
          stall = 1'b1;
          state_d = REQ;
          addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
          off_d = addr[1:0];
          f3_d = funct3;
          we_d = mem_write;
          wdata_d = mem_write ? wdata_fmt : '0;
          wstrb_d = wstrb_fmt;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_req_ready) state_d = we_q ? DONE : RESP;
      end
      RESP: begin
        stall = 1'b1;
        if (bus_rsp_valid) begin
          mem_data_d = ld_fmt;
          state_d = DONE;
        end
      end
      DONE: begin
        load_valid = ~we_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and captured request/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      off_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      off_q <= off_d;
      f3_q <= f3_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      mem_data_q <= mem_data_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, corner sequences and randomized accesses against a reference model
module tb_mem_access_unit;
  logic clk = 1'b0, rst_n;
  logic req_valid, mem_read, mem_write, stall, load_valid, fault;
  logic [2:0] funct3;
  logic [31:0] addr, store_data, mem_data, bus_addr, bus_wdata, bus_rdata;
  logic bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
  logic [3:0] bus_wstrb;
  int n_chk = 0, n_fail = 0, n_acc = 0;
  logic [31:0] exp_mem;
  typedef struct {
    logic rd, wr; logic [2:0] f3; logic [31:0] a, sd, rdata; int rdy, rsp;
    logic ef; logic [31:0] ew; logic [3:0] es; logic [31:0] em;
  } vec_t;
  vec_t vec[$];
  logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .mem_data(mem_data),
    .load_valid(load_valid), .fault(fault), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (bus_req_valid && bus_req_ready) n_acc <= n_acc + 1;

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                                output logic flt, output logic [31:0] wd, output logic [3:0] st,
                                output logic [31:0] ld);
    int size, o;
    longint v;
    size = 1 << f3[1:0];
    o = int'(a[1:0]);
    flt = (rd && wr) || f3[1:0] == 2'd3 || f3 == 3'd6 || (wr && f3[2]) || (o % size != 0);
    wd = 0;
    st = 0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = sd[8*(i % size) +: 8];
      if (wr && i >= o && i < o + size) st[i] = 1'b1;
    end
    v = longint'(rdata >> (8 * o)) & ((64'd1 << (8 * size)) - 64'd1);
    if (!f3[2] && v >= longint'(64'd1 << (8 * size - 1))) v = v - longint'(64'd1 << (8 * size));
    ld = v[31:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      mem_read = 1'($urandom);
      mem_write = 1'($urandom);
      funct3 = 3'($urandom);
      bus_req_ready = 1'($urandom);
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      ck("idle_stall", stall, 0);
      ck("idle_fault", fault, 0);
      ck("idle_reqv", bus_req_valid, 0);
      ck("idle_lv", load_valid, 0);
      step();
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata, input int rdy, input int rsp,
                        input logic ef, input logic [31:0] ew, input logic [3:0] es, input logic [31:0] em);
    req_valid = 1'b1;
    mem_read = rd;
    mem_write = wr;
    funct3 = f3;
    addr = a;
    store_data = sd;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    ck("fault", fault, ef);
    ck("stall_issue", stall, !ef);
    ck("reqv_issue", bus_req_valid, 0);
    if (ef) begin
      ck("mem_hold_fault", mem_data, em);
      step();
      return;
    end
    for (int k = 0; k <= rdy; k++) begin
      step();
      bus_req_ready = (k == rdy);
      bus_rsp_valid = 1'($urandom);
      bus_rdata = $urandom;
      @(negedge clk);
      ck("reqv", bus_req_valid, 1);
      ck("stall_req", stall, 1);
      ck("bus_we", bus_we, wr);
      ck("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      ck("bus_wstrb", bus_wstrb, es);
      if (wr) ck("bus_wdata", bus_wdata, ew);
    end
    if (rd) for (int k = 0; k <= rsp; k++) begin
      step();
      bus_req_ready = 1'b0;
      bus_rsp_valid = (k == rsp);
      bus_rdata = (k == rsp) ? rdata : $urandom;
      @(negedge clk);
      ck("stall_resp", stall, 1);
      ck("reqv_resp", bus_req_valid, 0);
      ck("lv_resp", load_valid, 0);
    end
    step();
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    ck("stall_done", stall, 0);
    ck("load_valid", load_valid, rd);
    ck("reqv_done", bus_req_valid, 0);
    ck("mem_data", mem_data, em);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ck("rst_stall", stall, 0);
    ck("rst_reqv", bus_req_valid, 0);
    ck("rst_we", bus_we, 0);
    ck("rst_wstrb", bus_wstrb, 0);
    ck("rst_addr", bus_addr, 0);
    ck("rst_wdata", bus_wdata, 0);
    ck("rst_mem", mem_data, 0);
    ck("rst_lv", load_valid, 0);
    step();
    rst_n = 1'b1;
    // reset while waiting for a load response
    req_valid = 1; mem_read = 1; funct3 = 3'd0; addr = 32'h1003;
    @(negedge clk);
    ck("rr_stall", stall, 1);
    step();
    bus_req_ready = 1;
    @(negedge clk);
    ck("rr_reqv", bus_req_valid, 1);
    step();
    bus_req_ready = 0;
    req_valid = 0;
    @(negedge clk);
    ck("rr_stall_resp", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    ck("rr_stall0", stall, 0);
    ck("rr_reqv0", bus_req_valid, 0);
    ck("rr_addr0", bus_addr, 0);
    ck("rr_mem0", mem_data, 0);
    step();
    bus_rsp_valid = 1; bus_rdata = 32'h1234_5678;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ck("rr_lv", load_valid, 0);
      ck("rr_mem", mem_data, 0);
      ck("rr_stall", stall, 0);
      step();
    end
    bus_rsp_valid = 0;
    idle(1);
    // directed table: rd wr f3 addr sd rdata rdy rsp | fault wdata wstrb mem_data
    vec.push_back('{1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 0, 32'h0, 4'h0, 32'hFFFF_FF80});
    vec.push_back('{0, 1, 3'd1, 32'h2002, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 32'hBEEF_BEEF, 4'hC, 32'hFFFF_FF80});
    vec.push_back('{1, 0, 3'd5, 32'h3002, 32'h0, 32'h8001_0000, 3, 0, 0, 32'h0, 4'h0, 32'h0000_8001});
    vec.push_back('{1, 0, 3'd2, 32'h4001, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'h0, 32'h0000_8001});
    vec.push_back('{1, 1, 3'd2, 32'h4000, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'h0, 32'h0000_8001});
    vec.push_back('{0, 1, 3'd0, 32'h5001, 32'h1234_5678, 32'h0, 1, 0, 0, 32'h7878_7878, 4'h2, 32'h0000_8001});
    vec.push_back('{1, 0, 3'd1, 32'h6000, 32'h0, 32'h1234_F00D, 0, 1, 0, 32'h0, 4'h0, 32'hFFFF_F00D});
    vec.push_back('{1, 0, 3'd4, 32'h7002, 32'h0, 32'h00AB_0000, 0, 0, 0, 32'h0, 4'h0, 32'h0000_00AB});
    vec.push_back('{1, 0, 3'd3, 32'h7000, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'h0, 32'h0000_00AB});
    vec.push_back('{0, 1, 3'd4, 32'h7000, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'h0, 32'h0000_00AB});
    vec.push_back('{1, 0, 3'd2, 32'h8000, 32'h0, 32'hCAFE_BABE, 0, 2, 0, 32'h0, 4'h0, 32'hCAFE_BABE});
    vec.push_back('{0, 1, 3'd2, 32'h9003, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'h0, 32'hCAFE_BABE});
    vec.push_back('{0, 1, 3'd2, 32'h9004, 32'h0102_0304, 32'h0, 0, 0, 0, 32'h0102_0304, 4'hF, 32'hCAFE_BABE});
    foreach (vec[i]) begin
      access(vec[i].rd, vec[i].wr, vec[i].f3, vec[i].a, vec[i].sd, vec[i].rdata, vec[i].rdy, vec[i].rsp,
             vec[i].ef, vec[i].ew, vec[i].es, vec[i].em);
      idle(1);
    end
    // back-to-back loads with req_valid held through DONE
    begin
      int a0;
      a0 = n_acc;
      access(1, 0, 3'd2, 32'hA000, 0, 32'h1111_1111, 0, 0, 0, 0, 4'h0, 32'h1111_1111);
      access(1, 0, 3'd1, 32'hA002, 0, 32'h7FFF_0000, 0, 0, 0, 0, 4'h0, 32'h0000_7FFF);
      idle(1);
      ck("b2b_requests", n_acc - a0, 2);
    end
    exp_mem = 32'h0000_7FFF;
    // randomized accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      logic rd, wr, flt;
      logic [2:0] f3;
      logic [31:0] a, sd, rdata, wd, ld;
      logic [3:0] st;
      int r, fl;
      r = $urandom % 8;
      rd = (r == 0) || (r < 5);
      wr = (r == 0) || (r >= 5);
      fl = $urandom % 10;
      f3 = (fl < 9) ? f3s[fl % 5] : 3'($urandom);
      a = $urandom;
      if ($urandom % 4 != 0)
        a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
      sd = $urandom;
      rdata = $urandom;
      model(rd, wr, f3, a, sd, rdata, flt, wd, st, ld);
      if (!flt && rd) exp_mem = ld;
      access(rd, wr, f3, a, sd, rdata, $urandom % 3, $urandom % 3, flt, wd, st, exp_mem);
      if ($urandom % 2 == 1) idle(1);
    end
    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit that produces the `mem_data` word consumed by the writeback result mux.
- Accepts one load or store per instruction from the pipeline and drives a valid/ready request/response data bus.
- Formats store data and byte strobes; aligns and sign- or zero-extends load data.
- Stalls the pipeline until the access completes and flags misaligned or illegal accesses without touching the bus.

Parameters:
DATA_WIDTH, 32, data word width (fixed at 32 for the RV32 byte lanes)
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  instruction in memory stage is valid
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  ADDR_WIDTH  byte address (ALU result)
store_data  input  DATA_WIDTH  rs2 value
stall  output  1  hold pipeline
mem_data  output  DATA_WIDTH  formatted load result, to writeback
load_valid  output  1  one-cycle pulse: mem_data updated
fault  output  1  one-cycle pulse: misaligned/illegal access, no bus activity
bus_req_valid  output  1  bus request valid
bus_req_ready  input  1  bus accepts request
bus_we  output  1  1 = write
bus_addr  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced 0)
bus_wdata  output  DATA_WIDTH  lane-replicated store data
bus_wstrb  output  4  byte enables (0000 on reads)
bus_rsp_valid  input  1  read data valid
bus_rdata  input  DATA_WIDTH  read word

Behaviour:
- Reset (async, any state):
  - FSM to IDLE.
  - stall, load_valid, fault, bus_req_valid, bus_we, bus_wstrb = 0.
  - bus_addr, bus_wdata, mem_data = 0.
  - An in-flight transaction is abandoned; a later bus_rsp_valid is ignored.
- start = req_valid & (mem_read | mem_write).
- Illegal when any of:
  - mem_read & mem_write both set;
  - funct3 ∈ {011, 110, 111};
  - store with funct3[2] = 1.
- Misaligned when:
  - H/HU with addr[0] = 1;
  - W with addr[1:0] != 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - start & (illegal | misaligned): fault = 1 this cycle (combinational), stall = 0, remain IDLE, no bus request.
  - start & legal: stall = 1 combinationally; register addr, funct3, we = mem_write, formatted wdata and wstrb; next state REQ.
- REQ:
  - bus_req_valid = 1; bus_we, bus_addr, bus_wdata, bus_wstrb come from registers and stay stable until accepted.
  - Accepted when bus_req_ready = 1 at a clock edge: write → DONE, read → RESP.
  - bus_rsp_valid in REQ is ignored.
  - stall = 1.
- RESP:
  - stall = 1.
  - On bus_rsp_valid, register formatted bus_rdata into mem_data; next state DONE.
  - Wait indefinitely otherwise.
- DONE:
  - stall = 0; load_valid = 1 only if the access was a read.
  - Next state IDLE unconditionally. req_valid is still high for the same instruction this cycle and must not restart an access.
- mem_data holds its value until the next load capture; stores never change it.
- Store formatting (o = addr[1:0]):
  - SB: wdata = {4{store_data[7:0]}}, wstrb = 0001 << o.
  - SH: wdata = {2{store_data[15:0]}}, wstrb = o[1] ? 1100 : 0011.
  - SW: wdata = store_data, wstrb = 1111.
- Load formatting:
  - s = bus_rdata >> (8*o).
  - LB = sext(s[7:0]), LBU = zext(s[7:0]).
  - LH = sext(s[15:0]), LHU = zext(s[15:0]).
  - LW = bus_rdata.
- Latency, zero-wait bus (ready high, response the cycle after acceptance):
  - Load: 4 cycles (IDLE, REQ, RESP, DONE); stall high for 3.
  - Store: 3 cycles; stall high for 2.
- Back-to-back accesses: next start is evaluated in IDLE the cycle after DONE.

Test Plan:
- LB, addr 0x1003, bus_rdata 0x80FF_1234 → bus_addr 0x1000, bus_wstrb 0000, mem_data 0xFFFF_FF80, load_valid pulse in cycle 3, stall high cycles 0–2.
- SH, addr 0x2002, store_data 0xDEAD_BEEF → bus_wdata 0xBEEF_BEEF, bus_wstrb 1100, bus_we 1; stall high 2 cycles; mem_data unchanged.
- LHU, addr 0x3002, bus_rdata 0x8001_0000, bus_req_ready held low 3 cycles → request fields stable throughout; mem_data 0x0000_8001; stall extends accordingly.
- LW, addr 0x4001, and SW with mem_read = mem_write = 1 → fault pulse 1 cycle each, bus_req_valid never asserted, stall 0.
- rst_n low while in RESP, then bus_rsp_valid → immediate return to IDLE, all outputs 0; response ignored; mem_data stays 0.
- Two consecutive loads with req_valid held high through DONE → exactly two bus requests, no duplicate issue in the DONE cycle.
